// File: rtl/wallace_mac_16.sv
// wallace_mac_16: a multiply-accumulate stage built around a Wallace-tree
// 16x16 multiplier.
//
// It accepts a stream of unsigned operand pairs over a valid/ready handshake
// and sums their products into a wide accumulator. When the beat flagged
// "last" has been summed, it presents the dot product on an output
// valid/ready handshake.
//
// Ports (wallace_mac_16):
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   in_valid     operand beat valid
//   in_ready     block can accept a beat this cycle (registered)
//   in_a, in_b   unsigned 16-bit operands
//   in_last      beat closes the current dot product
//   out_valid    result valid (registered)
//   out_ready    downstream accepts the result
//   out_acc      accumulated sum, modulo 2^ACC_WIDTH
//   out_count    number of beats summed, saturating
//   out_overflow sticky carry-out of the accumulator
//
// Ports (wallace_16bit):
//   a_i, b_i     unsigned 16-bit operands
//   product_o    exact 32-bit product

module wallace_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] product_o
);

  // Reduce the 16 partial-product rows with layers of 3:2 carry-save adders.
  // Row counts per layer are 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2.
  // The final two rows are then summed by one carry-propagate adder.
  // Each carry row is truncated to 32 bits. This is safe because every
  // row is non-negative and the exact product fits in 32 bits.
  function automatic logic [31:0] wallaceReduce(input logic [15:0] a,
                                                input logic [15:0] b);
    logic [31:0] rows [16];
    logic [31:0] nxt  [16];
    logic [31:0] x, y, z;
    int n;
    int m;
    for (int i = 0; i < 16; i++) begin
      rows[4'(i)] = b[4'(i)] ? ({16'b0, a} << i) : 32'b0;
    end
    n = 16;
    for (int stage = 0; stage < 6; stage++) begin
      m = 0;
      for (int k = 0; k < 16; k++) begin
        nxt[4'(k)] = 32'b0;
      end
      for (int g = 0; g < 5; g++) begin
        if (3 * g + 2 < n) begin
          x = rows[4'(3 * g)];
          y = rows[4'(3 * g + 1)];
          z = rows[4'(3 * g + 2)];
          nxt[4'(m)]     = x ^ y ^ z;
          nxt[4'(m + 1)] = ((x & y) | (x & z) | (y & z)) << 1;
          m = m + 2;
        end
      end
      // Rows left over after grouping by three pass straight to the next layer.
      for (int r = 0; r < 2; r++) begin
        if (3 * (n / 3) + r < n) begin
          nxt[4'(m)] = rows[4'(3 * (n / 3) + r)];
          m = m + 1;
        end
      end
      rows = nxt;
      n = m;
    end
    return rows[0] + rows[1];
  endfunction

  // The multiplier is purely combinational; the caller registers around it.
  always_comb begin
    product_o = wallaceReduce(a_i, b_i);
  end

endmodule

module wallace_mac_16 #(
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_a,
  input  logic [15:0]          in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow
);

  typedef enum logic [0:0] {ACCUM, HOLD} state_t;

  state_t               state_q, state_d;
  logic                 inReady_q, inReady_d;
  logic                 outValid_q, outValid_d;
  logic                 s1Valid_q, s1Valid_d;
  logic                 s1Last_q, s1Last_d;
  logic [15:0]          s1A_q, s1A_d;
  logic [15:0]          s1B_q, s1B_d;
  logic                 s2Valid_q, s2Valid_d;
  logic                 s2Last_q, s2Last_d;
  logic [31:0]          s2Prod_q, s2Prod_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [31:0]          product;
  logic [ACC_WIDTH:0]   accSum;

  wallace_16bit uMul (
    .a_i       (s1A_q),
    .b_i       (s1B_q),
    .product_o (product)
  );

  // Next-state logic for the two pipeline stages, the accumulator and the FSM.
  // in_ready is registered and computed from next-state values.
  // It therefore drops the cycle after a last beat is accepted.
  // It rises the cycle after the result handshake.
  always_comb begin
    accept    = in_valid && inReady_q;

    s1Valid_d = accept;
    s1Last_d  = accept && in_last;
    s1A_d     = accept ? in_a : s1A_q;
    s1B_d     = accept ? in_b : s1B_q;

    s2Valid_d = s1Valid_q;
    s2Last_d  = s1Valid_q && s1Last_q;
    s2Prod_d  = s1Valid_q ? product : s2Prod_q;

    accSum    = {1'b0, acc_q} + (ACC_WIDTH + 1)'(s2Prod_q);

    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    state_d   = state_q;

    case (state_q)
      ACCUM: begin
        if (s2Valid_q) begin
          acc_d   = accSum[ACC_WIDTH-1:0];
          count_d = (&count_q) ? count_q : count_q + 1'b1;
          ovf_d   = ovf_q | accSum[ACC_WIDTH];
          if (s2Last_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    inReady_d  = (state_d == ACCUM) && !s1Last_d && !s2Last_d;
    outValid_d = (state_d == HOLD);
  end

  // Single state register.
  // Reset drops every in-flight beat and any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      s1Valid_q  <= 1'b0;
      s1Last_q   <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s2Valid_q  <= 1'b0;
      s2Last_q   <= 1'b0;
      s2Prod_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inReady_q  <= inReady_d;
      outValid_q <= outValid_d;
      s1Valid_q  <= s1Valid_d;
      s1Last_q   <= s1Last_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s2Valid_q  <= s2Valid_d;
      s2Last_q   <= s2Last_d;
      s2Prod_q   <= s2Prod_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready     = inReady_q;
  assign out_valid    = outValid_q;
  assign out_acc      = acc_q;
  assign out_count    = count_q;
  assign out_overflow = ovf_q;

endmodule
